// File: rtl/softmax_pkg.sv
// Shared softmax datapath types.
// DATA_SIZE : default element width (signed two's complement)
// elem_t    : signed element / Xmax
// diff_t    : signed Xi - Xmax, one bit wider than an element
// state_t   : sub-max stage FSM states
package softmax_pkg;

    localparam int unsigned DATA_SIZE = 31;

    typedef logic signed [DATA_SIZE-1:0] elem_t;
    typedef logic signed [DATA_SIZE:0]   diff_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_MAX = 2'd2,
        REPLAY   = 2'd3
    } state_t;

endpackage

// File: rtl/softmax_sub_max_block_if.sv
// Stream bundle for the softmax sub-max stage.
// Input stream  : in_valid_i / in_ready_o / data_i
// Max strobe    : max_valid_i / data_max_i
// Output stream : out_valid_o / out_ready_i / data_o / out_last_o
// Status        : busy_o
// master = upstream/downstream side, slave = the block itself.
interface softmax_sub_max_block_if #(
    parameter int unsigned data_size = 31
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic signed [data_size-1:0] data_i;
    logic                        max_valid_i;
    logic signed [data_size-1:0] data_max_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic signed [data_size:0]   data_o;
    logic                        out_last_o;
    logic                        busy_o;

    modport master (
        output in_valid_i, data_i, max_valid_i, data_max_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, out_last_o, busy_o
    );

    modport slave (
        input  in_valid_i, data_i, max_valid_i, data_max_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, out_last_o, busy_o
    );
endinterface

// File: rtl/softmax_vec_buffer.sv
// Vector register file: vec_len entries of data_size bits.
// clock_i     : clock, rising edge
// i_wr_en     : write strobe
// i_wr_addr   : write index
// i_wr_data   : write data
// i_rd_addr   : read index
// o_rd_data_c : combinational read data
module softmax_vec_buffer #(
    parameter int unsigned vec_len   = 8,
    parameter int unsigned data_size = 31,
    localparam int unsigned addr_w   = $clog2(vec_len)
) (
    input  logic                 clock_i,
    input  logic                 i_wr_en,
    input  logic [addr_w-1:0]    i_wr_addr,
    input  logic [data_size-1:0] i_wr_data,
    input  logic [addr_w-1:0]    i_rd_addr,
    output logic [data_size-1:0] o_rd_data_c
);

    logic [data_size-1:0] r_mem [vec_len];

    // Storage only; contents are don't-care after reset.
    always_ff @(posedge clock_i) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/softmax_sub_max_block.sv
// Softmax stage 2: buffer one vector, wait for Xmax, replay Xi - Xmax.
// clock_i : clock, rising edge
// reset_i : synchronous reset, active-high
// bus     : slave side of softmax_sub_max_block_if (input stream,
//           max strobe, output stream, busy)
module softmax_sub_max_block
    import softmax_pkg::*;
#(
    parameter int unsigned data_size = DATA_SIZE,
    parameter int unsigned vec_len   = 8
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    softmax_sub_max_block_if.slave  bus
);

    localparam int unsigned addr_w = $clog2(vec_len);
    // Read pointer must reach vec_len to mark the replay as fully issued.
    localparam int unsigned cnt_w  = addr_w + 1;
    localparam logic [addr_w-1:0] LAST_WR = addr_w'(vec_len - 1);
    localparam logic [cnt_w-1:0]  LAST_RD = cnt_w'(vec_len - 1);
    localparam logic [cnt_w-1:0]  END_RD  = cnt_w'(vec_len);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [addr_w-1:0]           r_wr_ptr;
    logic [cnt_w-1:0]            r_rd_ptr;
    logic                        r_max_vld;
    logic signed [data_size-1:0] r_max;
    logic                        r_out_valid;
    logic signed [data_size:0]   r_data_o;
    logic                        r_out_last;
    logic                        r_in_ready;
    logic                        r_busy;

    logic                        w_in_xfer;
    logic                        w_last_in;
    logic                        w_out_xfer;
    logic                        w_out_load;
    logic                        w_replay_done;
    logic                        w_max_capture;
    logic [data_size-1:0]        w_rd_data;
    logic signed [data_size:0]   w_diff;

    assign w_in_xfer     = bus.in_valid_i && r_in_ready;
    assign w_last_in     = w_in_xfer && (r_wr_ptr == LAST_WR);
    assign w_out_xfer    = r_out_valid && bus.out_ready_i;
    assign w_out_load    = (r_state == REPLAY) && (!r_out_valid || bus.out_ready_i)
                           && (r_rd_ptr < END_RD);
    assign w_replay_done = (r_state == REPLAY) && w_out_xfer && r_out_last;
    // Only the first strobe outside REPLAY is kept.
    assign w_max_capture = bus.max_valid_i && !r_max_vld && (r_state != REPLAY);

    softmax_vec_buffer #(
        .vec_len   (vec_len),
        .data_size (data_size)
    ) u_buf (
        .clock_i     (clock_i),
        .i_wr_en     (w_in_xfer),
        .i_wr_addr   (r_wr_ptr),
        .i_wr_data   (bus.data_i),
        .i_rd_addr   (r_rd_ptr[addr_w-1:0]),
        .o_rd_data_c (w_rd_data)
    );

    // Both operands sign-extended by one bit, so the difference is exact.
    assign w_diff = {w_rd_data[data_size-1], w_rd_data} - {r_max[data_size-1], r_max};

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_in_xfer) w_next_state = LOAD;
            LOAD:     if (w_last_in) w_next_state = (r_max_vld || bus.max_valid_i) ? REPLAY : WAIT_MAX;
            WAIT_MAX: if (bus.max_valid_i) w_next_state = REPLAY;
            REPLAY:   if (w_replay_done) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // State register plus status flags decoded from the next state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == IDLE) || (w_next_state == LOAD);
            r_busy     <= (w_next_state != IDLE);
        end
    end

    // Pointers and max latch.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_max_vld <= 1'b0;
            r_max     <= '0;
        end else begin
            if (w_in_xfer) begin
                r_wr_ptr <= (r_wr_ptr == LAST_WR) ? '0 : r_wr_ptr + addr_w'(1);
            end
            if (w_replay_done) begin
                r_rd_ptr <= '0;
            end else if (w_out_load) begin
                r_rd_ptr <= r_rd_ptr + cnt_w'(1);
            end
            if (w_replay_done) begin
                r_max_vld <= 1'b0;
            end else if (w_max_capture) begin
                r_max_vld <= 1'b1;
                r_max     <= bus.data_max_i;
            end
        end
    end

    // Output register: holds while stalled, reloads on free slot.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_out_valid <= 1'b0;
            r_data_o    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_data_o    <= w_diff;
            r_out_last  <= (r_rd_ptr == LAST_RD);
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.busy_o      = r_busy;
    assign bus.out_valid_o = r_out_valid;
    assign bus.data_o      = r_data_o;
    assign bus.out_last_o  = r_out_last;

endmodule

// File: tb/tb_softmax_sub_max_block.sv
// Self-checking bench for softmax_sub_max_block (data_size=31, vec_len=8).
// Expected beats are queued when a vector is sent and consumed by the
// output monitor on every handshake.
module tb_softmax_sub_max_block;
    import softmax_pkg::*;

    localparam int unsigned VL = 8;

    logic clk = 1'b0;
    logic reset_i;
    int   checks   = 0;
    int   failures = 0;

    diff_t exp_d[$];
    bit    exp_l[$];
    elem_t vec[VL];

    softmax_sub_max_block_if #(.data_size(DATA_SIZE)) bus();

    softmax_sub_max_block #(
        .data_size (DATA_SIZE),
        .vec_len   (VL)
    ) dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every output transfer is compared against the queue head.
    always @(negedge clk) begin
        if (!reset_i && bus.out_valid_o && bus.out_ready_i) begin
            diff_t ed;
            bit    el;
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat data_o=%0d last=%0b required=no beat", bus.data_o, bus.out_last_o);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                if (bus.data_o !== ed || bus.out_last_o !== el) begin
                    failures++;
                    $display("FAIL beat data_o=%0d last=%0b required data_o=%0d last=%0b",
                             bus.data_o, bus.out_last_o, ed, el);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input diff_t d, input bit l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic push_vec_exp(input elem_t m);
        for (int i = 0; i < VL; i++) begin
            push_exp(diff_t'(vec[i]) - diff_t'(m), i == VL - 1);
        end
    endtask

    task automatic drive_elem(input elem_t x, input bit mv, input elem_t m);
        int n = 0;
        bus.in_valid_i  = 1'b1;
        bus.data_i      = x;
        bus.max_valid_i = mv;
        bus.data_max_i  = m;
        @(negedge clk);
        while (!bus.in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL in_accept_timeout in_ready_o=%0b required=1", bus.in_ready_o);
        end
        tick();
        bus.in_valid_i  = 1'b0;
        bus.max_valid_i = 1'b0;
    endtask

    // strobe_idx < 0: no max strobe alongside the elements.
    task automatic send_vec(input int strobe_idx, input elem_t m);
        for (int i = 0; i < VL; i++) begin
            drive_elem(vec[i], i == strobe_idx, (i == strobe_idx) ? m : '0);
        end
    endtask

    task automatic pulse_max(input elem_t m);
        bus.max_valid_i = 1'b1;
        bus.data_max_i  = m;
        tick();
        bus.max_valid_i = 1'b0;
    endtask

    task automatic wait_drain(output bit to);
        int n = 0;
        while (exp_d.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        to = (exp_d.size() != 0);
    endtask

    task automatic test_reset();
        reset_i         = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.max_valid_i = 1'b0;
        bus.data_max_i  = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", bus.out_valid_o); end
        if (bus.data_o !== '0) begin failures++; $display("FAIL reset_data_o got=%0d required=0", bus.data_o); end
        if (bus.out_last_o !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b required=0", bus.out_last_o); end
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b required=0", bus.busy_o); end
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready_o); end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w   = 0;
        int run = 0;
        for (int i = 0; i < VL; i++) begin
            vec[i] = elem_t'(i);
            push_exp(diff_t'(i - 7), i == VL - 1);
        end
        send_vec(-1, '0);
        checks += 3;
        if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL basic_wait_busy got=%0b required=1", bus.busy_o); end
        if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL basic_wait_in_ready got=%0b required=0", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_wait_out_valid got=%0b required=0", bus.out_valid_o); end
        tick();
        pulse_max(31'sd7);
        @(negedge clk);
        while (!bus.out_valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (bus.out_valid_o && run < 20) begin
            run++;
            @(negedge clk);
        end
        checks += 4;
        if (run != VL) begin failures++; $display("FAIL basic_consecutive_beats got=%0d required=%0d", run, VL); end
        if (exp_d.size() != 0) begin failures++; $display("FAIL basic_left_over got=%0d required=0", exp_d.size()); end
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL basic_end_busy got=%0b required=0", bus.busy_o); end
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL basic_end_in_ready got=%0b required=1", bus.in_ready_o); end
        tick();
    endtask

    task automatic test_negative();
        bit to;
        vec = '{-31'sd5, 31'sd3, -31'sd1, 31'sd3, 31'sd0, -31'sd2, 31'sd1, 31'sd2};
        push_exp(-32'sd8, 0); push_exp(32'sd0, 0); push_exp(-32'sd4, 0); push_exp(32'sd0, 0);
        push_exp(-32'sd3, 0); push_exp(-32'sd5, 0); push_exp(-32'sd2, 0); push_exp(-32'sd1, 1);
        send_vec(7, 31'sd3);
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL negative_drain left=%0d required=0", exp_d.size()); end

        for (int i = 0; i < VL; i++) vec[i] = '0;
        vec[0] = 31'sh4000_0000;
        push_exp(32'sh8000_0001, 0);
        for (int i = 1; i < VL; i++) push_exp(32'shC000_0001, i == VL - 1);
        send_vec(0, 31'sh3FFF_FFFF);
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL extreme_drain left=%0d required=0", exp_d.size()); end
    endtask

    task automatic test_max_early();
        bit to;
        // Strobe in IDLE, then a junk strobe of 99 during LOAD.
        pulse_max(31'sd5);
        for (int i = 0; i < VL; i++) vec[i] = elem_t'((i + 1) * 10);
        push_vec_exp(31'sd5);
        send_vec(3, 31'sd99);
        checks += 2;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++; $display("FAIL early_entry out_valid=%0b busy=%0b required out_valid=0 busy=1", bus.out_valid_o, bus.busy_o);
        end
        tick();
        if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'sd5) begin
            failures++; $display("FAIL early_beat0 out_valid=%0b data_o=%0d required out_valid=1 data_o=5", bus.out_valid_o, bus.data_o);
        end
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL early_drain left=%0d required=0", exp_d.size()); end

        // Strobe coincident with the last element.
        for (int i = 0; i < VL; i++) vec[i] = elem_t'(-3 * (i + 1));
        push_vec_exp(-31'sd4);
        send_vec(7, -31'sd4);
        checks += 2;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++; $display("FAIL coinc_entry out_valid=%0b busy=%0b required out_valid=0 busy=1", bus.out_valid_o, bus.busy_o);
        end
        tick();
        if (bus.out_valid_o !== 1'b1 || bus.data_o !== 32'sd1) begin
            failures++; $display("FAIL coinc_beat0 out_valid=%0b data_o=%0d required out_valid=1 data_o=1", bus.out_valid_o, bus.data_o);
        end
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL coinc_drain left=%0d required=0", exp_d.size()); end
    endtask

    task automatic test_backpressure();
        bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int    c      = 0;
        bit    prev_stall = 1'b0;
        diff_t prev_d = '0;
        bit    prev_l = 1'b0;
        vec = '{31'sd100, -31'sd100, 31'sd7, 31'sd8, 31'sd9, 31'sd10, 31'sd11, -31'sd12};
        push_vec_exp(31'sd11);
        send_vec(7, 31'sd11);
        while (bus.busy_o && c < 100) begin
            bus.out_ready_i = pat[c % 4];
            bus.in_valid_i  = c[0];
            bus.data_i      = 31'sd12345;
            @(negedge clk);
            checks++;
            if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b required=0", bus.in_ready_o); end
            if (prev_stall) begin
                checks++;
                if (bus.out_valid_o !== 1'b1 || bus.data_o !== prev_d || bus.out_last_o !== prev_l) begin
                    failures++;
                    $display("FAIL bp_hold valid=%0b data_o=%0d last=%0b required valid=1 data_o=%0d last=%0b",
                             bus.out_valid_o, bus.data_o, bus.out_last_o, prev_d, prev_l);
                end
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_d     = bus.data_o;
            prev_l     = bus.out_last_o;
            tick();
            c++;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        checks += 3;
        if (exp_d.size() != 0) begin failures++; $display("FAIL bp_left_over got=%0d required=0", exp_d.size()); end
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%0b required=0", bus.out_valid_o); end
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_end_in_ready got=%0b required=1", bus.in_ready_o); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0;
        for (int i = 0; i < 3; i++) drive_elem(elem_t'(500 + i), 1'b0, '0);
        reset_i = 1'b1;
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_load valid=%0b busy=%0b in_ready=%0b required 0/0/1", bus.out_valid_o, bus.busy_o, bus.in_ready_o);
        end
        reset_i = 1'b0;

        for (int i = 0; i < VL; i++) vec[i] = elem_t'(i + 1);
        push_vec_exp(31'sd20);
        send_vec(7, 31'sd20);
        while (exp_d.size() > 4 && n < 100) begin
            tick();
            n++;
        end
        reset_i = 1'b1;
        exp_d.delete();
        exp_l.delete();
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_replay valid=%0b busy=%0b in_ready=%0b required 0/0/1", bus.out_valid_o, bus.busy_o, bus.in_ready_o);
        end
        reset_i = 1'b0;
        repeat (3) tick();

        // Max sent late: a stale latched max would start the replay early.
        for (int i = 0; i < VL; i++) vec[i] = elem_t'(30 + i);
        push_vec_exp(31'sd10);
        send_vec(-1, '0);
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            failures++; $display("FAIL rst_stale_max valid=%0b busy=%0b required 0/1", bus.out_valid_o, bus.busy_o);
        end
        pulse_max(31'sd10);
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL rst_after_drain left=%0d required=0", exp_d.size()); end
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int i = 0; i < VL; i++) vec[i] = elem_t'(i + 1);
        push_vec_exp(31'sd50);
        send_vec(7, 31'sd50);
        for (int i = 0; i < VL; i++) vec[i] = elem_t'(100 + i);
        push_vec_exp(31'sd60);
        send_vec(-1, '0);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            failures++; $display("FAIL b2b_wait busy=%0b valid=%0b required 1/0", bus.busy_o, bus.out_valid_o);
        end
        pulse_max(31'sd60);
        wait_drain(to);
        checks++;
        if (to) begin failures++; $display("FAIL b2b_drain left=%0d required=0", exp_d.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_max_early();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
